// File: rtl/eel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eel_pkg : shared widths, fetch FSM states and decode packet type         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package eel_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/eel_ifetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eel_ifetch_fifo : sync FIFO of fetch packets with flush, count, full/empty|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module eel_ifetch_fifo
  import eel_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_data,
  input  logic          pop,
  output fetch_pkt_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_pkt_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/eel_ifetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eel_ifetch : EEL instruction-fetch front end (PC, IMEM requests, buffer)  |
// | Optional EEL_IFETCH_PERF_EN adds saturating stall/flush counters.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module eel_ifetch
  import eel_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [ILEN-1:0] dec_instr
`ifdef EEL_IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifetch_state_t   r_state;
  ifetch_state_t   w_state_n;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_n;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_tag_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_outst_n;
  logic [CW-1:0]   w_discard_n;
  logic [CW-1:0]   w_left;
  logic [CW-1:0]   w_count;
  logic            w_issue;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_redir;
  logic            w_full;
  logic            w_empty;
  fetch_pkt_t      w_head;
  fetch_pkt_t      w_push_pkt;

  assign w_redir    = redirect & (r_state != BOOT);
  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit rule: every in-flight request already owns a FIFO slot.
  assign imem_req  = (r_state == FETCH) && !w_full && (r_outst < CW'(MAX_OUTST)) &&
                     ((32'(r_outst) + 32'(w_count)) < FIFO_DEPTH);
  assign imem_addr = r_pc;

  assign w_issue   = imem_req & imem_gnt;
  // Responses with nothing in flight (e.g. stragglers from before a reset) are ignored.
  assign w_rsp     = imem_rvalid & (r_outst != '0);
  assign w_left    = r_outst - CW'(w_rsp);
  assign w_outst_n = w_left + CW'(w_issue);
  assign w_push    = w_rsp & (r_discard == '0) & ~w_redir;
  assign w_pop     = dec_valid & dec_ready;

  // Live requests are contiguous and end at r_pc-4, so the oldest one's PC follows directly.
  assign w_tag_pc   = r_pc - (XLEN'(r_outst - r_discard) << 2);
  assign w_push_pkt = '{pc: w_tag_pc, instr: imem_rdata};

  assign w_pc_n = w_redir ? w_redir_pc :
                  w_issue ? r_pc + 32'd4 : r_pc;

  assign w_discard_n = w_redir ? w_outst_n :
                       (w_rsp && (r_discard != '0)) ? r_discard - CW'(1) : r_discard;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      BOOT:    w_state_n = FETCH;
      FETCH:   if (w_redir && (w_left != '0)) w_state_n = DRAIN;
      DRAIN:   if (w_discard_n == '0) w_state_n = FETCH;
      default: w_state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_outst   <= w_outst_n;
      r_discard <= w_discard_n;
    end
  end

  eel_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (w_redir),
    .push      (w_push),
    .push_data (w_push_pkt),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign dec_valid = ~w_empty;
  assign dec_pc    = w_head.pc;
  assign dec_instr = w_head.instr;

`ifdef EEL_IFETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == FETCH) && !dec_valid && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redir && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
